// File: rtl/fwd_operand_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Purpose  : Shared constants for the operand-forwarding mux slice:
//            default operand/address widths, the select code meaning
//            "register file", the stage-to-select-code mapping and the
//            statistics counter width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package fwd_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W      = 16;

  // Select code 0 always means "take the register-file value".
  localparam int SEL_RF     = 0;

  // Forwarding stage k is reported as select code k+1.
  function automatic int stage_code(input int k);
    return k + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_operand_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_operand_mux_if
// Purpose  : Bundles the operand request, forwarding-stage bus and the
//            registered operand result of one forwarding mux instance.
// Ports    : master - pipeline side (drives request/forwarding/stall/flush)
//            slave  - forwarding mux (drives hazard and out_*)
// Revision : 1.0  initial release
// ============================================================================
interface fwd_operand_mux_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NFWD   = 2,
  parameter int SEL_W  = $clog2(NFWD + 1)
);
  logic                   in_valid;
  logic [REG_AW-1:0]      src_addr;
  logic [DATA_W-1:0]      rf_data;
  logic [NFWD*DATA_W-1:0] fwd_data;
  logic [NFWD*REG_AW-1:0] fwd_addr;
  logic [NFWD-1:0]        fwd_wen;
  logic [NFWD-1:0]        fwd_pend;
  logic                   stall;
  logic                   flush;
  logic                   hazard;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_sel;

  modport master (
    output in_valid, src_addr, rf_data, fwd_data, fwd_addr, fwd_wen,
           fwd_pend, stall, flush,
    input  hazard, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, src_addr, rf_data, fwd_data, fwd_addr, fwd_wen,
           fwd_pend, stall, flush,
    output hazard, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/fwd_operand_mux_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : fwd_prio_enc
// Purpose  : Per-stage destination/source address compare with
//            youngest-first (lowest index) priority encoding.
// Ports    : src_addr_i  source register address
//            fwd_addr_i  packed per-stage destination addresses
//            fwd_wen_i   per-stage write enables
//            fwd_pend_i  per-stage result-pending flags
//            match_o     some stage matches
//            idx_o       index of the winning (youngest) stage
//            pend_o      winning stage is pending
// Revision : 1.0  initial release
// ============================================================================
module fwd_prio_enc #(
  parameter int NFWD   = 2,
  parameter int REG_AW = 5,
  parameter int IDX_W  = (NFWD > 1) ? $clog2(NFWD) : 1
) (
  input  logic [REG_AW-1:0]      src_addr_i,
  input  logic [NFWD*REG_AW-1:0] fwd_addr_i,
  input  logic [NFWD-1:0]        fwd_wen_i,
  input  logic [NFWD-1:0]        fwd_pend_i,
  output logic                   match_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   pend_o
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  // Only the winner's pending flag matters: an older ready copy of the
  // register is stale and must never bypass a pending producer.
  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    pend_o  = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_wen_i[k] && (src_addr_i != '0) &&
          (fwd_addr_i[k*REG_AW +: REG_AW] == src_addr_i)) begin
        match_o = 1'b1;
        idx_o   = IDX_W'(k);
        pend_o  = fwd_pend_i[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_operand_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_operand_mux
// Purpose  : Operand forwarding mux with registered output stage. Selects
//            the youngest matching forwarding stage (or the register file),
//            flags a hazard when that stage is still pending, and registers
//            the operand under stall/flush control.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            bus        fwd_operand_mux_if.slave (request, stages, result)
//            fwd_cnt_o  saturating forwarded-operand count   (FWD_STATS_EN)
//            haz_cnt_o  saturating hazard-cycle count        (FWD_STATS_EN)
// Config   : FWD_STATS_EN adds the two statistics counters and their ports.
// Revision : 1.0  initial release
// ============================================================================
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int NFWD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  fwd_operand_mux_if.slave    bus
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]    fwd_cnt_o,
  output logic [CNT_W-1:0]    haz_cnt_o
`endif
);

  localparam int SEL_W = $clog2(NFWD + 1);
  localparam int IDX_W = (NFWD > 1) ? $clog2(NFWD) : 1;

  logic              match;
  logic [IDX_W-1:0]  win_idx;
  logic              win_pend;
  logic              hazard;
  logic [DATA_W-1:0] sel_data;
  logic [SEL_W-1:0]  sel_code;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;
  logic              load;

  fwd_prio_enc #(
    .NFWD   (NFWD),
    .REG_AW (REG_AW),
    .IDX_W  (IDX_W)
  ) u_prio_enc (
    .src_addr_i (bus.src_addr),
    .fwd_addr_i (bus.fwd_addr),
    .fwd_wen_i  (bus.fwd_wen),
    .fwd_pend_i (bus.fwd_pend),
    .match_o    (match),
    .idx_o      (win_idx),
    .pend_o     (win_pend)
  );

  always_comb begin
    sel_data = bus.rf_data;
    sel_code = SEL_W'(SEL_RF);
    if (match) begin
      sel_data = bus.fwd_data[win_idx*DATA_W +: DATA_W];
      sel_code = SEL_W'(stage_code(int'(win_idx)));
    end
  end

  // Hazard is independent of stall; the upstream hazard unit merges them.
  assign hazard = bus.in_valid && match && win_pend;

  // Priority below reset: flush > stall > load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    load    = 1'b0;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.in_valid && !hazard;
      if (valid_d) begin
        load   = 1'b1;
        data_d = sel_data;
        sel_d  = sel_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.hazard    = hazard;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] haz_cnt_q, haz_cnt_d;

  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    haz_cnt_d = haz_cnt_q;
    if (load && (sel_code != SEL_W'(SEL_RF)) && (fwd_cnt_q != '1))
      fwd_cnt_d = fwd_cnt_q + 1'b1;
    if (hazard && !bus.stall && (haz_cnt_q != '1))
      haz_cnt_d = haz_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_q <= '0;
      haz_cnt_q <= '0;
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
      haz_cnt_q <= haz_cnt_d;
    end
  end

  assign fwd_cnt_o = fwd_cnt_q;
  assign haz_cnt_o = haz_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_operand_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_operand_mux
// Purpose  : Self-checking bench for fwd_operand_mux (DATA_W=32, REG_AW=5,
//            NFWD=2): directed scenarios followed by random traffic, all
//            compared against a behavioural reference model.
// Config   : FWD_STATS_EN also checks the statistics counters.
// Revision : 1.0  initial release
// ============================================================================
module tb_fwd_operand_mux;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_operand_mux_if #(.DATA_W(DW), .REG_AW(AW), .NFWD(NF)) bus ();

`ifdef FWD_STATS_EN
  logic [15:0] fwd_cnt, haz_cnt;
`endif

  fwd_operand_mux #(.DATA_W(DW), .REG_AW(AW), .NFWD(NF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FWD_STATS_EN
    ,
    .fwd_cnt_o (fwd_cnt),
    .haz_cnt_o (haz_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference-model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_fcnt, m_hcnt;

  // Stimulus as unpacked per-stage arrays; packed onto the bus by drive().
  logic [31:0] s_data [NF];
  logic [4:0]  s_addr [NF];
  logic        s_wen  [NF];
  logic        s_pend [NF];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NF; k++) begin
      bus.fwd_data[k*DW +: DW] = s_data[k];
      bus.fwd_addr[k*AW +: AW] = s_addr[k];
      bus.fwd_wen[k]           = s_wen[k];
      bus.fwd_pend[k]          = s_pend[k];
    end
  endtask

  // Winning stage per the forwarding rules: -1 means register file.
  function automatic int winner();
    for (int k = 0; k < NF; k++)
      if (s_wen[k] && bus.src_addr != 0 && s_addr[k] == bus.src_addr) return k;
    return -1;
  endfunction

  // One cycle: check combinational hazard, clock, advance model, check outputs.
  task automatic step();
    int w;
    bit haz;
    drive();
    #1;
    w   = winner();
    haz = bus.in_valid && (w >= 0) && s_pend[w];
    chk("hazard", {31'd0, bus.hazard}, {31'd0, haz});
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_fcnt = 0; m_hcnt = 0;
    end else begin
      if (haz && !bus.stall && m_hcnt < 65535) m_hcnt++;
      if (bus.flush) m_valid = 0;
      else if (!bus.stall) begin
        m_valid = bus.in_valid && !haz;
        if (m_valid) begin
          m_sel  = w + 1;
          m_data = (w < 0) ? bus.rf_data : s_data[w];
          if (m_sel != 0 && m_fcnt < 65535) m_fcnt++;
        end
      end
    end
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("out_data", bus.out_data, m_data);
    chk("out_sel", {30'd0, bus.out_sel}, 32'(m_sel));
`ifdef FWD_STATS_EN
    chk("fwd_cnt", {16'd0, fwd_cnt}, 32'(m_fcnt));
    chk("haz_cnt", {16'd0, haz_cnt}, 32'(m_hcnt));
`endif
  endtask

  task automatic clear_stages();
    for (int k = 0; k < NF; k++) begin
      s_data[k] = '0; s_addr[k] = '0; s_wen[k] = 1'b0; s_pend[k] = 1'b0;
    end
  endtask

  initial begin
    m_valid = 0; m_data = 0; m_sel = 0; m_fcnt = 0; m_hcnt = 0;
    clear_stages();
    bus.in_valid = 1'b1;
    bus.src_addr = 5'd1;
    bus.rf_data  = 32'hDEAD_BEEF;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;

    // Reset held two cycles with a valid request present
    rst = 1'b1;
    step();
    step();
    chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_data", bus.out_data, 32'd0);
    rst = 1'b0;

    // No match
    bus.src_addr = 5'd3; bus.rf_data = 32'h11;
    s_addr[0] = 5'd5; s_addr[1] = 5'd6; s_wen[0] = 1; s_wen[1] = 1;
    step();
    chk("nomatch_data", bus.out_data, 32'h11);

    // Youngest-first priority, then older stage after clearing wen[0]
    bus.src_addr = 5'd7;
    s_addr[0] = 5'd7; s_addr[1] = 5'd7; s_data[0] = 32'hAA; s_data[1] = 32'hBB;
    step();
    chk("prio_young", bus.out_data, 32'hAA);
    s_wen[0] = 0;
    step();
    chk("prio_old", bus.out_data, 32'hBB);

    // Register 0 is never forwarded
    bus.src_addr = 5'd0; bus.rf_data = 32'h1234;
    s_addr[0] = 5'd0; s_wen[0] = 1; s_data[0] = 32'hFF;
    step();
    chk("zero_reg", bus.out_data, 32'h1234);

    // Pending youngest producer blocks an older ready one
    bus.src_addr = 5'd4;
    s_addr[0] = 5'd4; s_pend[0] = 1; s_addr[1] = 5'd4; s_data[1] = 32'h22;
    step();
    chk("haz_bubble", {31'd0, bus.out_valid}, 32'd0);
    s_pend[0] = 0; s_data[0] = 32'h33;
    step();
    chk("haz_clear", bus.out_data, 32'h33);

    // Stall holds, flush wins over stall
    clear_stages();
    bus.src_addr = 5'd9; bus.rf_data = 32'h55;
    step();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.rf_data = $urandom; bus.src_addr = 5'($urandom_range(1, 31));
      step();
    end
    chk("stall_hold", bus.out_data, 32'h55);
    bus.flush = 1;
    step();
    chk("flush_data", bus.out_data, 32'h55);
    bus.stall = 0; bus.flush = 0;

    // in_valid low drops out_valid
    bus.in_valid = 0;
    step();

    // Random traffic on a narrow address range to provoke matches
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 7) != 0);
      bus.src_addr = 5'($urandom_range(0, 3));
      bus.rf_data  = $urandom;
      for (int k = 0; k < NF; k++) begin
        s_data[k] = $urandom;
        s_addr[k] = 5'($urandom_range(0, 3));
        s_wen[k]  = 1'($urandom_range(0, 1));
        s_pend[k] = ($urandom_range(0, 3) == 0);
      end
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwd_operand_mux.md
# fwd_operand_mux

Parametrised operand-forwarding multiplexer with a registered output stage for the pipelined MIPS datapath. It generalises the fixed 3-input, 5-bit select mux to DATA_W-bit operands and NFWD forwarding stages. Selection is computed internally from register-address matches rather than taken as an external select. It sits between ID/EX and the ALU input, with one instance per source operand (rs, rt). It detects un-forwardable (pending) producers, raises a hazard, and holds or bubbles its output register under stall/flush control.

## Interface
- DATA_W, 32, operand width in bits
- REG_AW, 5, register-address width; address 0 is hardwired zero and never matched
- NFWD, 2, number of forwarding stages; index 0 = youngest (EX/MEM), index NFWD-1 = oldest (MEM/WB)
- SEL_W, $clog2(NFWD+1), width of the source-select code
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request valid this cycle
- src_addr  in  REG_AW  source register address of the operand
- rf_data  in  DATA_W  register-file read value
- fwd_data  in  NFWD*DATA_W  per-stage result, stage k at bits [k*DATA_W +: DATA_W]
- fwd_addr  in  NFWD*REG_AW  per-stage destination address
- fwd_wen  in  NFWD  per-stage register-write enable
- fwd_pend  in  NFWD  per-stage result not yet available (e.g. load still in flight)
- stall  in  1  hold output register
- flush  in  1  invalidate output register
- hazard  out  1  combinational; youngest matching stage is pending
- out_valid  out  1  registered operand valid
- out_data  out  DATA_W  registered operand
- out_sel  out  SEL_W  registered source code: 0 = register file, k+1 = stage k
- fwd_cnt  out  16  forwarded-operand count (FWD_STATS_EN only)
- haz_cnt  out  16  hazard-cycle count (FWD_STATS_EN only)

## Operation
- Stage k matches when `fwd_wen[k] && fwd_addr[k] == src_addr && src_addr != 0`.
- The lowest-index matching stage wins (youngest-first priority). If no stage matches, the source is rf_data with sel = 0.
- hazard = in_valid && the winning stage has fwd_pend set. Older non-pending matches are ignored; stale data is never forwarded past a pending producer.
- Register update priority is rst > flush > stall > load:
  - rst: out_valid = 0, out_data = 0, out_sel = 0, counters = 0.
  - flush: out_valid = 0. out_data and out_sel are unchanged.
  - stall (no flush): all output registers hold.
  - otherwise: out_valid <= in_valid && !hazard. When that is 1, out_data and out_sel load the selected source; otherwise they hold.
- Stall does not suppress hazard. The upstream hazard unit combines both signals.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears on out_* after edge N.
- hazard is purely combinational from the same-cycle inputs, with zero latency.
- Throughput is one operand per cycle when there is no stall or hazard.
- A hazard cycle produces a bubble at the next edge (out_valid = 0). The data registers keep their last value.
- Asserting rst mid-stream clears the register at the next edge regardless of stall, flush, or in_valid.
- flush and stall asserted together: flush wins.
- in_valid = 0 with no stall: out_valid drops to 0 at the next edge.

## Configuration
- FWD_STATS_EN defined: fwd_cnt and haz_cnt exist as saturating 16-bit counters, both reset to 0.
  - fwd_cnt increments on each load with sel != 0.
  - haz_cnt increments on each cycle with hazard = 1 and stall = 0.
  - Both saturate at 16'hFFFF.
- FWD_STATS_EN undefined: the counters and both ports are removed, and the datapath behaviour is otherwise identical.

## Structure
- Package fwd_pkg holds:
  - the SEL_RF = 0 constant and the stage-to-code mapping (k+1);
  - default widths DATA_W = 32 and REG_AW = 5;
  - the counter width of 16.
- Sub-module fwd_prio_enc (parametrised NFWD, REG_AW) contains the per-stage address compare and youngest-first priority encode. It outputs a match flag, a winning index, and a pending flag. The top level holds the mux, hazard gate, output register and counters.

## Test plan
- Reset: hold rst for 2 cycles with in_valid = 1 → out_valid = 0, out_data = 0, out_sel = 0, counters = 0.
- No match: src_addr = 3, rf_data = 0x11, fwd_addr = {5, 6}, fwd_wen = 2'b11 → next cycle out_data = 0x11, out_sel = 0.
- Priority: src_addr = 7, both stages addr 7, wen = 1, stage0 = 0xAA, stage1 = 0xBB → out_data = 0xAA, out_sel = 1. Clear wen[0] → out_data = 0xBB, out_sel = 2.
- Zero register: src_addr = 0, stage0 addr 0, wen = 1, data = 0xFF → out_data = rf_data, out_sel = 0.
- Hazard: src_addr = 4, stage0 addr 4, pend = 1, stage1 addr 4, data = 0x22 → hazard = 1 and out_valid = 0 next cycle. Drop pend with stage0 data = 0x33 → out_data = 0x33, out_valid = 1.
- Stall/flush: load 0x55, then stall for 3 cycles with changing inputs → output held at 0x55. Then assert stall and flush together → out_valid = 0 and out_data stays 0x55.
